// File: rtl/ikaopm_dac_serializer.sv
// ikaopm_dac_serializer
// Converts captured 16-bit signed L/R sums into the DAC's 3-bit exponent +
// 10-bit offset-binary mantissa format and shifts each word out LSB-first on
// o_SO, one bit per enabled phi1 cycle.
// Optional build macro IKAOPM_DAC_PARALLEL_OUT_EN adds o_EMU_L / o_EMU_R /
// o_EMU_VALID, which carry the linear value the DAC would reconstruct.
module ikaopm_dac_serializer #(
    parameter int PAD_BITS = 3          // zero bits ahead of the mantissa, 0..3
) (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_LOAD_L,
    input  logic        i_LOAD_R,
    input  logic [15:0] i_ACC_L,
    input  logic [15:0] i_ACC_R,
    output logic        o_SO,
    output logic        o_SO_CH,
    output logic        o_BUSY,
    output logic        o_FRAME_ERR
`ifdef IKAOPM_DAC_PARALLEL_OUT_EN
    ,
    output logic [15:0] o_EMU_L,
    output logic [15:0] o_EMU_R,
    output logic        o_EMU_VALID
`endif
);

    localparam int         F        = PAD_BITS + 13;
    localparam logic [3:0] LAST_BIT = 4'(F - 1);

    // capture stage
    logic [15:0]  cap_x_q,   cap_x_d;
    logic         cap_tag_q, cap_tag_d;
    logic         cap_vld_q, cap_vld_d;
    // shift stage
    logic [F-1:0] sr_q,      sr_d;
    logic [3:0]   cnt_q,     cnt_d;
    logic         ch_q,      ch_d;
    logic         busy_q,    busy_d;
    logic         err_q,     err_d;

    // float conversion of the captured sample
    logic [5:0]   sign_chg;
    logic [2:0]   exp_w;
    logic [9:0]   man_raw;
    logic [F-1:0] word;

    // sign_chg[gi] flags a difference between bits gi+10 and gi+9; the highest
    // such pair decides how far the mantissa window must slide up.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_sign_chg
            assign sign_chg[gi] = cap_x_q[gi + 10] ^ cap_x_q[gi + 9];
        end
    endgenerate

    // Priority-encode the exponent, slice the 10-bit mantissa window and pack
    // {exponent, offset-binary mantissa, padding zeros}.
    always_comb begin
        exp_w = 3'd1;
        for (int k = 0; k < 6; k++) begin
            if (sign_chg[k]) exp_w = 3'(k + 2);
        end
        man_raw = 10'(cap_x_q >> (exp_w - 3'd1));
        word    = F'({exp_w, ~man_raw[9], man_raw[8:0]}) << PAD_BITS;
    end

    // Next-state: stage 2 (load shifter from capture, or shift), then stage 1.
    always_comb begin
        cap_x_d   = cap_x_q;
        cap_tag_d = cap_tag_q;
        cap_vld_d = 1'b0;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        busy_d    = busy_q;
        err_d     = err_q;

        if (cap_vld_q) begin
            sr_d   = word;
            cnt_d  = 4'd0;
            busy_d = 1'b1;
            ch_d   = cap_tag_q;
            // a restart before the last bit truncates the running frame
            if (busy_q && (cnt_q < LAST_BIT)) err_d = 1'b1;
        end else if (busy_q) begin
            sr_d = sr_q >> 1;
            if (cnt_q == LAST_BIT) busy_d = 1'b0;
            else                   cnt_d  = cnt_q + 4'd1;
        end

        cap_vld_d = i_LOAD_L | i_LOAD_R;
        if (i_LOAD_L) begin
            cap_x_d   = i_ACC_L;
            cap_tag_d = 1'b0;
        end else if (i_LOAD_R) begin
            cap_x_d   = i_ACC_R;
            cap_tag_d = 1'b1;
        end
        // colliding strobes: left is kept, right is lost
        if (i_LOAD_L && i_LOAD_R) err_d = 1'b1;
    end

    // Registers advance only on enabled phi1 edges; reset is sampled there too.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_phi1_NCEN_n) begin
            if (!i_MRST_n) begin
                cap_x_q   <= '0;
                cap_tag_q <= 1'b0;
                cap_vld_q <= 1'b0;
                sr_q      <= '0;
                cnt_q     <= '0;
                ch_q      <= 1'b0;
                busy_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                cap_x_q   <= cap_x_d;
                cap_tag_q <= cap_tag_d;
                cap_vld_q <= cap_vld_d;
                sr_q      <= sr_d;
                cnt_q     <= cnt_d;
                ch_q      <= ch_d;
                busy_q    <= busy_d;
                err_q     <= err_d;
            end
        end
    end

    assign o_SO        = sr_q[0];
    assign o_SO_CH     = ch_q;
    assign o_BUSY      = busy_q;
    assign o_FRAME_ERR = err_q;

`ifdef IKAOPM_DAC_PARALLEL_OUT_EN
    logic [15:0] emu_l_q, emu_l_d;
    logic [15:0] emu_r_q, emu_r_d;
    logic        emu_vld_q, emu_vld_d;
    logic [15:0] lin;

    // Rebuild the DAC's linear value (signed mantissa scaled by the exponent)
    // and steer it to the channel register at stage 2.
    always_comb begin
        lin       = {{6{man_raw[9]}}, man_raw} << (exp_w - 3'd1);
        emu_l_d   = emu_l_q;
        emu_r_d   = emu_r_q;
        emu_vld_d = cap_vld_q;
        if (cap_vld_q) begin
            if (cap_tag_q) emu_r_d = lin;
            else           emu_l_d = lin;
        end
    end

    // Parallel outputs share the enabled-edge update and reset behaviour.
    always_ff @(posedge i_EMUCLK) begin
        if (!i_phi1_NCEN_n) begin
            if (!i_MRST_n) begin
                emu_l_q   <= '0;
                emu_r_q   <= '0;
                emu_vld_q <= 1'b0;
            end else begin
                emu_l_q   <= emu_l_d;
                emu_r_q   <= emu_r_d;
                emu_vld_q <= emu_vld_d;
            end
        end
    end

    assign o_EMU_L     = emu_l_q;
    assign o_EMU_R     = emu_r_q;
    assign o_EMU_VALID = emu_vld_q;
`endif

endmodule

// File: tb/tb_ikaopm_dac_serializer.sv
// Bench for ikaopm_dac_serializer: table of conversion vectors, directed
// multi-cycle sequences and a randomized run, all scored against a
// frame-schedule reference model.
module tb_ikaopm_dac_serializer;

    localparam int PAD = 3;
    localparam int F   = PAD + 13;

    logic        clk = 1'b0;
    logic        mrst_n, ncen_n, load_l, load_r;
    logic [15:0] acc_l, acc_r;
    logic        so, so_ch, busy, frame_err;
`ifdef IKAOPM_DAC_PARALLEL_OUT_EN
    logic [15:0] emu_l, emu_r;
    logic        emu_valid;
`endif

    ikaopm_dac_serializer #(.PAD_BITS(PAD)) dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (mrst_n),
        .i_phi1_NCEN_n (ncen_n),
        .i_LOAD_L      (load_l),
        .i_LOAD_R      (load_r),
        .i_ACC_L       (acc_l),
        .i_ACC_R       (acc_r),
        .o_SO          (so),
        .o_SO_CH       (so_ch),
        .o_BUSY        (busy),
        .o_FRAME_ERR   (frame_err)
`ifdef IKAOPM_DAC_PARALLEL_OUT_EN
        ,
        .o_EMU_L       (emu_l),
        .o_EMU_R       (emu_r),
        .o_EMU_VALID   (emu_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference arithmetic ----------------
    // exponent = smallest e in 1..7 whose (e+9)-bit signed range holds x
    function automatic int ref_exp(input logic [15:0] x);
        int v = int'($signed(x));
        int e = 7;
        for (int k = 7; k >= 1; k--)
            if (v >= -(1 << (k + 8)) && v < (1 << (k + 8))) e = k;
        return e;
    endfunction

    function automatic int ref_raw(input logic [15:0] x);
        int v = int'($signed(x));
        return (v >>> (ref_exp(x) - 1)) & 'h3FF;
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] x);
        int w = (ref_exp(x) << (10 + PAD)) | ((ref_raw(x) ^ 'h200) << PAD);
        return 16'(w);
    endfunction

    function automatic logic [15:0] ref_lin(input logic [15:0] x);
        int s = ref_raw(x);
        if (s >= 512) s = s - 1024;
        return 16'(s * (1 << (ref_exp(x) - 1)));
    endfunction

    // ---------------- frame-schedule model ----------------
    int          ecount = 0;     // enabled edges seen
    bit          m_have = 0;     // a frame has been started since reset
    int          m_start = 0;    // enabled edge on which that frame was loaded
    logic [15:0] m_word = '0;
    bit          m_tag = 0;
    bit          m_pend = 0;
    logic [15:0] m_px = '0;
    bit          m_ptag = 0;
    bit          m_err = 0;
    logic [15:0] m_emu_l = '0, m_emu_r = '0;
    bit          m_emu_vld = 0;

    task automatic model_edge(input bit rst_n, input bit ll, input bit lr,
                              input logic [15:0] al, input logic [15:0] ar);
        ecount++;
        if (!rst_n) begin
            m_have = 0; m_tag = 0; m_pend = 0; m_err = 0;
            m_emu_l = '0; m_emu_r = '0; m_emu_vld = 0;
        end else begin
            m_emu_vld = 0;
            if (m_pend) begin
                if (m_have && (ecount - m_start) < F) m_err = 1;
                m_have = 1; m_start = ecount; m_word = ref_word(m_px); m_tag = m_ptag;
                if (m_ptag) m_emu_r = ref_lin(m_px);
                else        m_emu_l = ref_lin(m_px);
                m_emu_vld = 1;
            end
            m_pend = ll | lr;
            m_px   = ll ? al : ar;
            m_ptag = !ll;
            if (ll && lr) m_err = 1;
        end
    endtask

    // One clock: drive, edge, then compare every output against the model.
    task automatic cyc(input bit en, input bit rst_n, input bit ll, input bit lr,
                       input logic [15:0] al, input logic [15:0] ar);
        int  d;
        bit  e_busy, e_so;
        ncen_n = !en; mrst_n = rst_n; load_l = ll; load_r = lr; acc_l = al; acc_r = ar;
        @(posedge clk);
        #1;
        if (en) model_edge(rst_n, ll, lr, al, ar);
        d      = ecount - m_start;
        e_busy = m_have && d < F;
        e_so   = e_busy ? m_word[d] : 1'b0;
        chk("so",   int'(so),        int'(e_so));
        chk("busy", int'(busy),      int'(e_busy));
        chk("ch",   int'(so_ch),     int'(m_tag));
        chk("err",  int'(frame_err), int'(m_err));
`ifdef IKAOPM_DAC_PARALLEL_OUT_EN
        chk("emu_l",   int'(emu_l),     int'(m_emu_l));
        chk("emu_r",   int'(emu_r),     int'(m_emu_r));
        chk("emu_vld", int'(emu_valid), int'(m_emu_vld));
`endif
    endtask

    task automatic idle();
        cyc(1, 1, 0, 0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 16'h0, 16'h0);
        idle();
    endtask

    typedef struct {
        logic [15:0] x;
        bit          tag;
        logic [15:0] word;
    } vec_t;

    vec_t        tab[5];
    logic [15:0] stream_exp[4];
    logic [15:0] specials[6];

    initial begin
        tab[0] = '{16'h0001, 1'b0, 16'h3008};
        tab[1] = '{16'h7FFF, 1'b1, 16'hFFF8};
        tab[2] = '{16'h8000, 1'b1, 16'hE000};
        tab[3] = '{16'hFFFF, 1'b0, 16'h2FF8};
        tab[4] = '{16'h1234, 1'b0, 16'hB918};
        stream_exp[0] = 16'h3008; stream_exp[1] = 16'hFFF8;
        stream_exp[2] = 16'h2FF8; stream_exp[3] = 16'hE000;
        specials[0] = 16'h0001; specials[1] = 16'h7FFF; specials[2] = 16'h8000;
        specials[3] = 16'hFFFF; specials[4] = 16'h0200; specials[5] = 16'hFE00;

        mrst_n = 0; ncen_n = 0; load_l = 0; load_r = 0; acc_l = '0; acc_r = '0;

        // ---- reset state ----
        cyc(1, 0, 1, 1, 16'h1111, 16'h2222);
        cyc(1, 0, 0, 0, 16'h0, 16'h0);
        chk("rst_so",   int'(so),        0);
        chk("rst_busy", int'(busy),      0);
        chk("rst_ch",   int'(so_ch),     0);
        chk("rst_err",  int'(frame_err), 0);
        idle();
        chk("rst_load_ignored", int'(busy), 0);

        // ---- table: single conversions ----
        for (int v = 0; v < 5; v++) begin
            logic [15:0] got;
            int          blen;
            bit          ch0;
            do_reset();
            cyc(1, 1, !tab[v].tag, tab[v].tag, tab[v].x, tab[v].x);
            chk("busy_before_bit0", int'(busy), 0);
            got = '0; blen = 0; ch0 = 0;
            for (int k = 0; k < 16; k++) begin
                idle();
                got[k] = so;
                if (busy) blen++;
                if (k == 0) ch0 = so_ch;
            end
            idle();
            if (busy) blen++;
            chk("tab_word", int'(got), int'(tab[v].word));
            chk("tab_ch",   int'(ch0), int'(tab[v].tag));
            chk("tab_blen", blen, 16);
            chk("tab_err",  int'(frame_err), 0);
            $display("vec %0d: x=%04h ch=%0d word=%04h busy_len=%0d", v, tab[v].x, ch0, got, blen);
        end

        // ---- back-to-back L/R frames ----
        begin
            logic [63:0] stream;
            int          blen;
            do_reset();
            stream = '0; blen = 0;
            for (int t = 0; t <= 64; t++) begin
                if (t < 64 && t % 16 == 0) begin
                    if ((t / 16) % 2 == 0) cyc(1, 1, 1, 0, stream_exp[t / 16] == 16'h3008 ? 16'h0001 : 16'hFFFF, 16'h0);
                    else                   cyc(1, 1, 0, 1, 16'h0, stream_exp[t / 16] == 16'hFFF8 ? 16'h7FFF : 16'h8000);
                end else begin
                    idle();
                end
                if (t >= 1) begin
                    stream[t - 1] = so;
                    if (busy) blen++;
                    if ((t - 1) % 16 == 0) chk("b2b_ch", int'(so_ch), ((t - 1) / 16) % 2);
                end
            end
            for (int f = 0; f < 4; f++) begin
                chk("b2b_word", int'(stream[16 * f +: 16]), int'(stream_exp[f]));
                $display("b2b frame %0d: word=%04h", f, stream[16 * f +: 16]);
            end
            chk("b2b_busy_len", blen, 64);
            chk("b2b_err", int'(frame_err), 0);
        end

        // ---- simultaneous strobes ----
        begin
            logic [15:0] got;
            do_reset();
            cyc(1, 1, 1, 1, 16'h0001, 16'h7FFF);
            chk("sim_err_set", int'(frame_err), 1);
            got = '0;
            for (int k = 0; k < 16; k++) begin
                idle();
                got[k] = so;
            end
            chk("sim_word", int'(got), 16'h3008);
            chk("sim_ch", int'(so_ch), 0);
            $display("simultaneous: word=%04h err=%0d", got, frame_err);
        end

        // ---- truncation by a second load ----
        begin
            logic [4:0]  old_bits;
            logic [15:0] got;
            do_reset();
            cyc(1, 1, 1, 0, 16'h0001, 16'h0);
            for (int t = 1; t <= 5; t++) begin
                if (t == 5) cyc(1, 1, 0, 1, 16'h0, 16'h8000);
                else        idle();
                old_bits[t - 1] = so;
            end
            chk("trunc_err_pre", int'(frame_err), 0);
            got = '0;
            for (int k = 0; k < 16; k++) begin
                idle();
                got[k] = so;
                if (k == 0) chk("trunc_err_set", int'(frame_err), 1);
            end
            chk("trunc_old_bits", int'(old_bits), 5'h08);
            chk("trunc_new_word", int'(got), 16'hE000);
            for (int k = 0; k < 20; k++) idle();
            chk("trunc_err_sticky", int'(frame_err), 1);
            $display("truncate: old=%02h new=%04h err=%0d", old_bits, got, frame_err);
        end

        // ---- reset mid-frame, then clock-enable gating ----
        do_reset();
        cyc(1, 1, 1, 1, 16'h7FFF, 16'h0001);
        for (int t = 1; t <= 8; t++) idle();
        chk("mid_bit7", int'(so), 1);
        cyc(1, 0, 1, 1, 16'h1234, 16'h1234);
        chk("mid_rst_so",   int'(so),        0);
        chk("mid_rst_busy", int'(busy),      0);
        chk("mid_rst_err",  int'(frame_err), 0);
        idle();
        chk("mid_rst_noload", int'(busy), 0);
        cyc(1, 1, 0, 1, 16'h0, 16'h8000);
        for (int t = 0; t < 3; t++) idle();
        for (int t = 0; t < 6; t++) cyc(0, t % 2, 1, 1, 16'hAAAA, 16'h5555);
        chk("gate_busy", int'(busy), 1);
        chk("gate_err",  int'(frame_err), 0);
        for (int t = 0; t < 16; t++) idle();
        $display("reset/gating sequence done");

`ifdef IKAOPM_DAC_PARALLEL_OUT_EN
        // ---- parallel reconstruction ----
        do_reset();
        cyc(1, 1, 1, 0, 16'h1234, 16'h0);
        idle();
        chk("emu_1234", int'(emu_l), 16'h1230);
        chk("emu_vld_hi", int'(emu_valid), 1);
        idle();
        chk("emu_vld_lo", int'(emu_valid), 0);
        for (int t = 0; t < 14; t++) idle();
        cyc(1, 1, 1, 0, 16'hFFFF, 16'h0);
        idle();
        chk("emu_ffff", int'(emu_l), 16'hFFFF);
        chk("emu_vld_hi2", int'(emu_valid), 1);
        idle();
        chk("emu_vld_lo2", int'(emu_valid), 0);
        $display("parallel: L=%04h R=%04h", emu_l, emu_r);
`endif

        // ---- randomized run against the model ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          en, rn, ll, lr;
            logic [15:0] al, ar;
            en = ($urandom % 4) != 0;
            rn = ($urandom % 250) != 0;
            ll = ($urandom % 14) == 0;
            lr = ($urandom % 14) == 0;
            al = ($urandom % 3 == 0) ? specials[$urandom % 6] : 16'($urandom);
            ar = ($urandom % 3 == 0) ? specials[$urandom % 6] : 16'($urandom);
            cyc(en, rn, ll, lr, al, ar);
        end
        $display("random run: %0d enabled edges", ecount);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
